// File: rtl/data_mem_unit_pkg.sv
// Shared constants, debug FSM encoding and store-buffer entry type for the
// data-memory stage.
package data_mem_unit_pkg;

    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int SB_DEPTH = 4;
    localparam int PTR_W    = $clog2(SB_DEPTH);
    localparam int CNT_W    = $clog2(SB_DEPTH + 1);

    localparam logic [0:0] DBG_IDLE = 1'b0;
    localparam logic [0:0] DBG_ACK  = 1'b1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;

    typedef sb_entry_t [SB_DEPTH-1:0] sb_array_t;

    // Walks oldest to youngest so the last hit (youngest) wins; returns {hit, data}.
    function automatic logic [DW:0] sb_lookup(
        input sb_array_t        ent,
        input logic [PTR_W-1:0] head,
        input logic [CNT_W-1:0] count,
        input logic [AW-1:0]    a
    );
        logic [DW:0]      res;
        logic [PTR_W-1:0] idx;
        res = {1'b0, {DW{1'b0}}};
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (ent[idx].addr == a)) begin
                res = {1'b1, ent[idx].data};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_unit_store_buffer.sv
// FIFO store buffer with count/full status and two youngest-match lookup
// ports (core load path and debug read path).
module data_mem_unit_store_buffer
    import data_mem_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  sb_entry_t        push_entry_i,
    input  logic             pop_i,
    output sb_entry_t        head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    input  logic [AW-1:0]    core_addr_i,
    output logic             core_hit_o,
    output logic [DW-1:0]    core_data_o,
    input  logic [AW-1:0]    dbg_addr_i,
    output logic             dbg_hit_o,
    output logic [DW-1:0]    dbg_data_o
);

    sb_array_t        ent_q;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_s;
    logic [DW:0]      core_lk_s;
    logic [DW:0]      dbg_lk_s;

    assign pop_s = pop_i && (count_q != {CNT_W{1'b0}});

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            tail_d = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            head_d = head_q;
        end
        case ({push_i, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; a reset discards pending entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful under the valid count.
    always_ff @(posedge clk) begin
        if (rst && push_i) begin
            ent_q[tail_q] <= push_entry_i;
        end
    end

    // Youngest-match lookups for both read paths.
    always_comb begin
        core_lk_s = sb_lookup(ent_q, head_q, count_q, core_addr_i);
        dbg_lk_s  = sb_lookup(ent_q, head_q, count_q, dbg_addr_i);
    end

    assign core_hit_o  = core_lk_s[DW];
    assign core_data_o = core_lk_s[DW-1:0];
    assign dbg_hit_o   = dbg_lk_s[DW];
    assign dbg_data_o  = dbg_lk_s[DW-1:0];
    assign head_o      = ent_q[head_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == CNT_W'(SB_DEPTH));

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: store buffer draining into the data array, forwarding
// load path, and a debug read port that competes with the drain.
module data_mem_unit
    import data_mem_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_write,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    wdata,
    output logic [DW-1:0]    rdata,
    input  logic             dbg_req,
    input  logic [AW-1:0]    dbg_addr,
    output logic             dbg_ack,
    output logic [DW-1:0]    dbg_data,
    output logic             sb_full,
    output logic [CNT_W-1:0] sb_count,
    output logic             drain_idle
);

    logic [DW-1:0]    mem_q [0:(1<<AW)-1];
    logic [0:0]       state_q, state_d;
    logic             dbg_ack_q, dbg_ack_d;
    logic [DW-1:0]    dbg_data_q, dbg_data_d;
    logic             grant_s;
    logic             pop_s;
    sb_entry_t        push_entry_s;
    sb_entry_t        head_s;
    logic [CNT_W-1:0] count_s;
    logic             full_s;
    logic             core_hit_s, dbg_hit_s;
    logic [DW-1:0]    core_data_s, dbg_sb_data_s;
    logic [DW-1:0]    dbg_fwd_s;

    assign push_entry_s = '{addr: addr, data: wdata};

    data_mem_unit_store_buffer u_sb (
        .clk          (clk),
        .rst          (rst),
        .push_i       (mem_write),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .head_o       (head_s),
        .count_o      (count_s),
        .full_o       (full_s),
        .core_addr_i  (addr),
        .core_hit_o   (core_hit_s),
        .core_data_o  (core_data_s),
        .dbg_addr_i   (dbg_addr),
        .dbg_hit_o    (dbg_hit_s),
        .dbg_data_o   (dbg_sb_data_s)
    );

    assign rdata     = core_hit_s ? core_data_s : mem_q[addr];
    assign dbg_fwd_s = dbg_hit_s ? dbg_sb_data_s : mem_q[dbg_addr];

    // Debug FSM; a grant is refused when full so the drain keeps room for stores.
    always_comb begin
        state_d    = state_q;
        dbg_ack_d  = 1'b0;
        dbg_data_d = dbg_data_q;
        grant_s    = 1'b0;
        case (state_q)
            DBG_IDLE: begin
                if (dbg_req && !full_s) begin
                    grant_s    = 1'b1;
                    state_d    = DBG_ACK;
                    dbg_ack_d  = 1'b1;
                    dbg_data_d = dbg_fwd_s;
                end else begin
                    state_d = DBG_IDLE;
                end
            end
            DBG_ACK: begin
                state_d = DBG_IDLE;
            end
            default: begin
                state_d = DBG_IDLE;
            end
        endcase
    end

    assign pop_s = (count_s != {CNT_W{1'b0}}) && !grant_s;

    // Debug FSM and registered debug outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= DBG_IDLE;
            dbg_ack_q  <= 1'b0;
            dbg_data_q <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            dbg_ack_q  <= dbg_ack_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    // Array write port, fed only by the buffer head; never written during reset.
    always_ff @(posedge clk) begin
        if (rst && pop_s) begin
            mem_q[head_s.addr] <= head_s.data;
        end
    end

    assign dbg_ack    = dbg_ack_q;
    assign dbg_data   = dbg_data_q;
    assign sb_full    = full_s;
    assign sb_count   = count_s;
    assign drain_idle = (count_s == {CNT_W{1'b0}});

endmodule
